// File: rtl/if_inst_queue_pkg.sv
// Shared definitions for the fetch-to-decode instruction queue.
//   IQ_NOP      : instruction word shown on the head when the queue is empty
//   IQ_ENTRY_W  : stored entry width {excp, pc, inst}
//   IQ_*_LO/HI  : field offsets inside a stored entry
//   iq_pack()   : builds a stored entry from its fields
package if_inst_queue_pkg;

    localparam int          IQ_ENTRY_W = 65;
    localparam logic [31:0] IQ_NOP     = 32'h0000_0000;

    localparam int IQ_INST_LO = 0;
    localparam int IQ_INST_HI = 31;
    localparam int IQ_PC_LO   = 32;
    localparam int IQ_PC_HI   = 63;
    localparam int IQ_EXCP    = 64;

    function automatic logic [IQ_ENTRY_W-1:0] iq_pack(input logic        excp,
                                                       input logic [31:0] pc,
                                                       input logic [31:0] inst);
        return {excp, pc, inst};
    endfunction

endpackage

// File: rtl/if_inst_queue_ptr_ctrl.sv
// Pointer controller (iq_ptr_ctrl) for the instruction queue.
// Owns the read/write pointers, the occupancy count and the handshake enables.
//   clk, rst           : clock, asynchronous active-high reset
//   flush              : clear the queue at the next edge; blocks same-cycle push
//   push_valid/ready   : fetch-side handshake (push_ready depends on count and flush only)
//   pop_ready/valid    : decode-side handshake
//   wr_en              : write strobe for the storage slot at wr_ptr
//   wr_ptr, rd_ptr     : storage slot indices, wrap modulo DEPTH
//   count              : occupancy 0..DEPTH
module if_inst_queue_ptr_ctrl #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic             pop_ready,
    output logic             pop_valid,
    output logic             wr_en,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [PTR_W:0]   count
);

    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_en, pop_en;

    // No full bypass: a pop on a full queue does not open push_ready this cycle,
    // which keeps pop_ready out of the push_ready path.
    assign push_ready = (count_q != CNT_W'(DEPTH)) & ~flush;
    assign pop_valid  = (count_q != '0);
    assign push_en    = push_valid & push_ready;
    // A pop during flush is still a handshake: ID has already taken the head.
    assign pop_en     = pop_valid & pop_ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it
        // unassigned, which would infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({push_en, pop_en})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_en  = push_en;
    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign count  = count_q;

endmodule

// File: rtl/if_inst_queue.sv
// Fetch-to-decode instruction queue. Buffers {pc, inst, fetch exception} entries from
// the instruction bus and presents them in order to ID.
//   clk, rst                       : clock, asynchronous active-high reset
//   flush                          : discard all entries (redirect / exception / eret)
//   push_valid/ready, push_pc/inst/excp : fetch-side entry offer
//   pop_valid/ready, pop_pc/inst/excp   : head entry towards ID (zero / NOP when empty)
//   count                          : occupancy 0..DEPTH
module if_inst_queue
    import if_inst_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           push_valid,
    output logic           push_ready,
    input  logic [31:0]    push_pc,
    input  logic [31:0]    push_inst,
    input  logic           push_excp,
    output logic           pop_valid,
    input  logic           pop_ready,
    output logic [31:0]    pop_pc,
    output logic [31:0]    pop_inst,
    output logic           pop_excp,
    output logic [PTR_W:0] count
);

    logic [IQ_ENTRY_W-1:0] mem_q [DEPTH];
    logic [IQ_ENTRY_W-1:0] head;
    logic                  wr_en;
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;

    if_inst_queue_ptr_ctrl #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ptr_ctrl (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .pop_ready  (pop_ready),
        .pop_valid  (pop_valid),
        .wr_en      (wr_en),
        .wr_ptr     (wr_ptr),
        .rd_ptr     (rd_ptr),
        .count      (count)
    );

    // NOTE: the storage array has no reset; stale slots are never visible because the
    // head is masked whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr] <= iq_pack(push_excp, push_pc, push_inst);
    end

    // Head is read straight from the rd_ptr slot; an entry written this edge shows up
    // only after count has become non-zero, so there is no same-cycle flow-through.
    assign head     = mem_q[rd_ptr];
    assign pop_inst = pop_valid ? head[IQ_INST_HI:IQ_INST_LO] : IQ_NOP;
    assign pop_pc   = pop_valid ? head[IQ_PC_HI:IQ_PC_LO]     : 32'h0;
    assign pop_excp = pop_valid & head[IQ_EXCP];

endmodule

// File: tb/tb_if_inst_queue.sv
module tb_if_inst_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic           clk;
    logic           rst;
    logic           flush;
    logic           push_valid;
    logic           push_ready;
    logic [31:0]    push_pc;
    logic [31:0]    push_inst;
    logic           push_excp;
    logic           pop_valid;
    logic           pop_ready;
    logic [31:0]    pop_pc;
    logic [31:0]    pop_inst;
    logic           pop_excp;
    logic [PTR_W:0] count;

    if_inst_queue #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_pc    (push_pc),
        .push_inst  (push_inst),
        .push_excp  (push_excp),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .pop_pc     (pop_pc),
        .pop_inst   (pop_inst),
        .pop_excp   (pop_excp),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Scoreboard / reference model: the queue contents as an ordered list of
    // {excp, pc, inst} tuples. Accepted pushes append, handshaken pops remove the
    // front, flush and reset empty it.
    logic [64:0] model_q[$];
    int          exp_sz;
    logic [64:0] exp_head;

    // Monitor: samples on the falling edge, compares the DUT against the model, then
    // applies this cycle's handshakes to the model.
    always @(negedge clk) begin
        if (rst) begin
            model_q.delete();
            check("rst_count", 65'(count), 65'(0));
            check("rst_pop_valid", 65'(pop_valid), 65'(0));
        end else begin
            exp_sz   = model_q.size();
            exp_head = (exp_sz != 0) ? model_q[0] : 65'(0);
            check("count", 65'(count), 65'(exp_sz));
            check("pop_valid", 65'(pop_valid), 65'(exp_sz != 0));
            check("push_ready", 65'(push_ready), 65'((exp_sz != DEPTH) && !flush));
            check("head", {pop_excp, pop_pc, pop_inst}, exp_head);
            if (exp_sz != 0 && pop_ready) void'(model_q.pop_front());
            if (flush) model_q.delete();
            else if (push_valid && exp_sz < DEPTH)
                model_q.push_back({push_excp, push_pc, push_inst});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] inst, input logic excp);
        push_valid = 1'b1;
        push_pc    = pc;
        push_inst  = inst;
        push_excp  = excp;
    endtask

    task automatic drain();
        idle();
        pop_ready = 1'b1;
        repeat (DEPTH + 1) step();
        pop_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        idle();
        push_pc   = '0;
        push_inst = '0;
        push_excp = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        step();

        // 1: asynchronous reset mid-stream, between edges
        for (int i = 0; i < 3; i++) begin
            offer(32'h0000_1000 + 32'(4 * i), 32'h1111_0000 + 32'(i), 1'b0);
            step();
        end
        idle();
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_count", 65'(count), 65'(0));
        check("async_rst_pop_valid", 65'(pop_valid), 65'(0));
        check("async_rst_pop_inst", 65'(pop_inst), 65'(0));
        check("async_rst_push_ready", 65'(push_ready), 65'(1));
        @(negedge clk);
        #1;
        rst = 1'b0;
        step();

        // 2: fill to full, 5th push held until a pop
        for (int i = 0; i < 4; i++) begin
            offer(32'hBFC0_0000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0);
            step();
        end
        offer(32'hBFC0_0010, 32'hA000_0004, 1'b0);
        #1;
        check("full_count", 65'(count), 65'(4));
        check("full_push_ready", 65'(push_ready), 65'(0));
        repeat (2) step();
        pop_ready = 1'b1;
        step();
        step();
        push_valid = 1'b0;
        repeat (4) step();
        idle();
        step();

        // 3: steady stream from count=1 across several pointer wraps
        offer(32'h0000_2000, 32'h2222_0000, 1'b0);
        step();
        pop_ready = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            offer(32'h0000_2000 + 32'(4 * i), 32'h2222_0000 + 32'(i), 1'b0);
            step();
        end
        drain();

        // 4: flush with concurrent push and pop at count=2
        offer(32'h0000_3000, 32'h3333_0000, 1'b0);
        step();
        offer(32'h0000_3004, 32'h3333_0001, 1'b0);
        step();
        offer(32'h0000_3008, 32'h2408_0001, 1'b0);
        pop_ready = 1'b1;
        flush     = 1'b1;
        step();
        idle();
        #1;
        check("flush_count", 65'(count), 65'(0));
        check("flush_pop_inst", 65'(pop_inst), 65'(0));
        step();

        // 5: exception-tagged entry followed by a normal one
        offer(32'h0000_0003, 32'hDEAD_BEEF, 1'b1);
        step();
        offer(32'h0000_0004, 32'h3C08_BFC0, 1'b0);
        step();
        idle();
        #1;
        check("excp_head_excp", 65'(pop_excp), 65'(1));
        check("excp_head_pc", 65'(pop_pc), 65'(32'h0000_0003));
        drain();

        // 6: pop_ready while empty, then confirm the pointers still line up
        pop_ready = 1'b1;
        repeat (3) step();
        idle();
        offer(32'h0000_4000, 32'h4444_0000, 1'b0);
        step();
        drain();

        // Randomised traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            push_valid = ($urandom_range(0, 3) != 0);
            pop_ready  = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 31) == 0);
            push_pc    = $urandom;
            push_inst  = $urandom;
            push_excp  = ($urandom_range(0, 7) == 0);
            step();
        end
        drain();

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
